// File: rtl/sc_vga_fb_reader.sv
// 640x480@60 Hz monochrome VGA scan-out of the D_MEM frame buffer (byte 0x5000, 1 bpp).
// Define SC_VGA_TEST_PATTERN_EN to add the TestPatternEn input and the checkerboard pattern.
module sc_vga_fb_reader #(
  parameter int unsigned CLK_PER_PIXEL = 2,
  parameter logic [13:0] FB_WORD_BASE  = 14'h1400,
  parameter logic [11:0] FG_COLOR      = 12'hFFF,
  parameter logic [11:0] BG_COLOR      = 12'h000
) (
`ifdef SC_VGA_TEST_PATTERN_EN
  input  logic        TestPatternEn,
`endif
  input  logic        Clk,
  input  logic        Rst,
  output logic        FbRdEn,
  output logic [13:0] FbRdWordAddr,
  input  logic [31:0] FbRdData,
  output logic        VgaHsync,
  output logic        VgaVsync,
  output logic [3:0]  VgaRed,
  output logic [3:0]  VgaGreen,
  output logic [3:0]  VgaBlue
);

  localparam int unsigned TW = $clog2(CLK_PER_PIXEL);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_PER_PIXEL - 1);

  localparam logic [9:0] H_VIS     = 10'd640;
  localparam logic [9:0] H_SYNC_S  = 10'd656;
  localparam logic [9:0] H_SYNC_E  = 10'd751;
  localparam logic [9:0] H_LAST    = 10'd799;
  localparam logic [9:0] H_PREF    = 10'd792;
  localparam logic [9:0] V_VIS     = 10'd480;
  localparam logic [9:0] V_SYNC_S  = 10'd490;
  localparam logic [9:0] V_SYNC_E  = 10'd491;
  localparam logic [9:0] V_LAST    = 10'd524;
  localparam logic [6:0] GRP_PER_LINE = 7'd80;

  logic [TW-1:0] r_tick_cnt;
  logic [9:0]    r_hcnt;
  logic [9:0]    r_vcnt;
  logic          r_fb_rd_en;
  logic [13:0]   r_fb_addr;
  logic [1:0]    r_lane;
  logic          r_rd_pend;
  logic [7:0]    r_staging;
  logic [7:0]    r_shift;
  logic          r_hsync;
  logic          r_vsync;
  logic [11:0]   r_rgb;

  logic          w_tick;
  logic          w_test_pat;
  logic [9:0]    w_hcnt_nxt;
  logic [9:0]    w_vcnt_nxt;
  logic          w_grp_start;
  logic [6:0]    w_fgrp;
  logic [9:0]    w_fy;
  logic [7:0]    w_frow;
  logic [13:0]   w_word_idx;
  logic [13:0]   w_rd_addr;
  logic          w_issue;
  logic [7:0]    w_lane_byte;
  logic [7:0]    w_pix_bits;
  logic          w_pix_on;
  logic          w_visible;
  logic          w_hsync_nxt;
  logic          w_vsync_nxt;
  logic [11:0]   w_rgb_nxt;

`ifdef SC_VGA_TEST_PATTERN_EN
  assign w_test_pat = TestPatternEn;
`else
  assign w_test_pat = 1'b0;
`endif

  assign w_tick = (r_tick_cnt == TICK_LAST);

  always_comb begin
    w_hcnt_nxt = r_hcnt + 10'd1;
    w_vcnt_nxt = r_vcnt;
    if (r_hcnt == H_LAST) begin
      w_hcnt_nxt = '0;
      w_vcnt_nxt = (r_vcnt == V_LAST) ? 10'd0 : r_vcnt + 10'd1;
    end
  end

  // Prefetch target is the next 8-pixel group, possibly on the following line.
  always_comb begin
    w_grp_start = (r_hcnt[2:0] == 3'd0);
    w_fgrp      = 7'd0;
    w_fy        = r_vcnt;
    if (r_hcnt >= H_PREF) begin
      w_fy = (r_vcnt == V_LAST) ? 10'd0 : r_vcnt + 10'd1;
    end else begin
      w_fgrp = r_hcnt[9:3] + 7'd1;
    end
    w_frow     = w_fy[9:2];
    w_word_idx = {w_frow, 6'b0} + {2'b0, w_frow, 4'b0} + {7'b0, w_fgrp};
    w_rd_addr  = FB_WORD_BASE + w_word_idx;
    w_issue    = w_tick && w_grp_start && (w_fgrp < GRP_PER_LINE) && (w_fy < V_VIS)
                 && !w_test_pat;
  end

  assign w_lane_byte = FbRdData[8*r_lane +: 8];

  // At a group boundary Shift is being reloaded this tick, so take the bit from Staging.
  always_comb begin
    w_pix_bits  = w_grp_start ? r_staging : r_shift;
    w_pix_on    = w_test_pat ? (r_hcnt[3] ^ r_vcnt[3]) : w_pix_bits[r_hcnt[2:0]];
    w_visible   = (r_hcnt < H_VIS) && (r_vcnt < V_VIS);
    w_hsync_nxt = !((r_hcnt >= H_SYNC_S) && (r_hcnt <= H_SYNC_E));
    w_vsync_nxt = !((r_vcnt >= V_SYNC_S) && (r_vcnt <= V_SYNC_E));
    w_rgb_nxt   = 12'h000;
    if (w_visible) begin
      w_rgb_nxt = w_pix_on ? FG_COLOR : BG_COLOR;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_tick_cnt <= '0;
      r_hcnt     <= H_PREF;
      r_vcnt     <= V_LAST;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
      r_hcnt     <= w_hcnt_nxt;
      r_vcnt     <= w_vcnt_nxt;
    end else begin
      r_tick_cnt <= r_tick_cnt + TW'(1);
    end
  end

  // Read data returns one Clk after FbRdEn; r_rd_pend marks that cycle.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_fb_rd_en <= 1'b0;
      r_fb_addr  <= '0;
      r_lane     <= '0;
      r_rd_pend  <= 1'b0;
      r_staging  <= '0;
    end else begin
      r_rd_pend  <= r_fb_rd_en;
      r_fb_rd_en <= w_issue;
      if (w_issue) begin
        r_fb_addr <= w_rd_addr;
        r_lane    <= w_fy[1:0];
      end
      if (r_rd_pend) begin
        r_staging <= w_lane_byte;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_shift <= '0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_rgb   <= '0;
    end else if (w_tick) begin
      if (w_grp_start && (r_hcnt < H_VIS)) begin
        r_shift <= r_staging;
      end
      r_hsync <= w_hsync_nxt;
      r_vsync <= w_vsync_nxt;
      r_rgb   <= w_rgb_nxt;
    end
  end

  assign FbRdEn       = r_fb_rd_en;
  assign FbRdWordAddr = r_fb_addr;
  assign VgaHsync     = r_hsync;
  assign VgaVsync     = r_vsync;
  assign VgaRed       = r_rgb[11:8];
  assign VgaGreen     = r_rgb[7:4];
  assign VgaBlue      = r_rgb[3:0];

endmodule
